// File: rtl/mux_tdm_sampler.sv
// rtl/mux_tdm_sampler.sv - two-channel TDM sampler driving a 2:1 mux select, with word handshake.
// Optional registered word parity output enabled by defining MUX_TDM_PARITY_EN.
module mux_tdm_sampler #(
  parameter int WIDTH  = 8,
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             y,
  output logic             s,
  output logic [WIDTH-1:0] ch0_data,
  output logic [WIDTH-1:0] ch1_data,
  output logic             valid,
  input  logic             ready,
`ifdef MUX_TDM_PARITY_EN
  output logic             par,
`endif
  output logic             overrun
);

  localparam int BW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [3:0]    SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [BW-1:0] BIT_LAST    = BW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             s_q, s_d;
  logic [3:0]       settle_q, settle_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [WIDTH-1:0] sh0_q, sh0_d;
  logic [WIDTH-1:0] sh1_q, sh1_d;
  logic [WIDTH-1:0] ch0_q, ch0_d;
  logic [WIDTH-1:0] ch1_q, ch1_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             complete;
`ifdef MUX_TDM_PARITY_EN
  logic             par_q, par_d;
`endif

  always_comb begin
    state_d   = state_q;
    s_d       = s_q;
    settle_d  = settle_q;
    bit_d     = bit_q;
    sh0_d     = sh0_q;
    sh1_d     = sh1_q;
    ch0_d     = ch0_q;
    ch1_d     = ch1_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    complete  = 1'b0;
`ifdef MUX_TDM_PARITY_EN
    par_d     = par_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d  = ST_SETTLE;
          s_d      = 1'b0;
          settle_d = '0;
          bit_d    = '0;
        end
      end
      ST_SETTLE: begin
        if (!en) begin
          state_d  = ST_IDLE;
          s_d      = 1'b0;
          settle_d = '0;
          bit_d    = '0;
          sh0_d    = '0;
          sh1_d    = '0;
        end else if (settle_q == SETTLE_LAST) begin
          state_d  = ST_SAMPLE;
          settle_d = '0;
        end else begin
          settle_d = settle_q + 4'd1;
        end
      end
      ST_SAMPLE: begin
        if (!en) begin
          state_d  = ST_IDLE;
          s_d      = 1'b0;
          settle_d = '0;
          bit_d    = '0;
          sh0_d    = '0;
          sh1_d    = '0;
        end else begin
          state_d = ST_SETTLE;
          s_d     = ~s_q;
          if (!s_q) begin
            sh0_d = {sh0_q[WIDTH-2:0], y};
          end else begin
            sh1_d = {sh1_q[WIDTH-2:0], y};
            // A word ends on the channel-1 capture of its last bit.
            if (bit_q == BIT_LAST) begin
              bit_d    = '0;
              complete = 1'b1;
            end else begin
              bit_d = bit_q + BW'(1);
            end
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        s_d     = 1'b0;
      end
    endcase

    // A pending word blocks a new one unless it is being taken at this same edge.
    if (complete) begin
      if (valid_q && !ready) begin
        overrun_d = 1'b1;
      end else begin
        ch0_d   = sh0_d;
        ch1_d   = sh1_d;
        valid_d = 1'b1;
`ifdef MUX_TDM_PARITY_EN
        par_d   = ^{sh1_d, sh0_d};
`endif
      end
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      s_q       <= 1'b0;
      settle_q  <= '0;
      bit_q     <= '0;
      sh0_q     <= '0;
      sh1_q     <= '0;
      ch0_q     <= '0;
      ch1_q     <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
`ifdef MUX_TDM_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      s_q       <= s_d;
      settle_q  <= settle_d;
      bit_q     <= bit_d;
      sh0_q     <= sh0_d;
      sh1_q     <= sh1_d;
      ch0_q     <= ch0_d;
      ch1_q     <= ch1_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
`ifdef MUX_TDM_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

  assign s        = s_q;
  assign ch0_data = ch0_q;
  assign ch1_data = ch1_q;
  assign valid    = valid_q;
  assign overrun  = overrun_q;
`ifdef MUX_TDM_PARITY_EN
  assign par      = par_q;
`endif

endmodule
